// File: rtl/nrm_drain.sv
// Snapshot-and-drain normalizer: captures every core's (sign, exp, acc) on start,
// then streams each channel as an fp32 word through a 2-stage pipe with valid/ready/last.
module nrm_drain #(
  parameter int F_NUM      = 16,
  parameter int EXP_W      = 10,
  parameter int ACC_W      = 32,
  parameter int MANT_SHIFT = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [6:0]               nch,
  input  logic                     relu,
  input  logic [F_NUM-1:0]         signo,
  input  logic [F_NUM*EXP_W-1:0]   expo,
  input  logic [F_NUM*ACC_W-1:0]   addo,
  output logic                     dst_valid,
  output logic [31:0]              dst_data,
  output logic                     dst_last,
  input  logic                     dst_ready,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     clr_ovr,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam int P_W = $clog2(ACC_W);
  localparam int E_W = EXP_W + 10;

  logic [1:0]             state_q, state_d;
  logic [6:0]             cnt_q, cnt_d, n_q, n_d;
  logic                   relu_q, relu_d;
  logic [F_NUM-1:0]       sgn_snap_q, sgn_snap_d;
  logic [F_NUM*EXP_W-1:0] exp_snap_q, exp_snap_d;
  logic [F_NUM*ACC_W-1:0] acc_snap_q, acc_snap_d;
  logic                   s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_sign_q, s1_sign_d;
  logic [EXP_W-1:0]       s1_exp_q, s1_exp_d;
  logic [ACC_W-1:0]       s1_mag_q, s1_mag_d;
  logic [P_W-1:0]         s1_pos_q, s1_pos_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [31:0]            out_data_q, out_data_d;
  logic                   ovr_q, ovr_d;

  logic                   advance, issue;
  logic [ACC_W-1:0]       sel_acc, sel_mag;
  logic [EXP_W-1:0]       sel_exp;
  logic                   sel_sgn;
  logic [P_W-1:0]         sel_pos, norm_sh;
  logic [E_W-1:0]         e_sum;
  logic [ACC_W+22:0]      norm;
  logic [22:0]            mant;
  logic [31:0]            packed_word;

  // Handshake: a word transfers on a cycle where dst_valid & dst_ready are both high;
  // while dst_valid is high and dst_ready low, dst_data/dst_last hold and the whole pipe stalls.
  assign advance = !out_valid_q || dst_ready;
  assign issue   = (state_q == ST_DRAIN) && (!s1_valid_q || advance);

  // Stage 1 front end: magnitude and leading-one position of the selected snapshot channel.
  always_comb begin
    sel_acc = acc_snap_q[cnt_q*ACC_W +: ACC_W];
    sel_exp = exp_snap_q[cnt_q*EXP_W +: EXP_W];
    sel_sgn = sgn_snap_q[cnt_q];
    sel_mag = sel_acc[ACC_W-1] ? (~sel_acc + ACC_W'(1)) : sel_acc;
    sel_pos = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (sel_mag[i]) sel_pos = P_W'(i);
    end
  end

  // Stage 2: biased exponent, truncated mantissa and special-case selection.
  always_comb begin
    e_sum   = {{10{s1_exp_q[EXP_W-1]}}, s1_exp_q} + E_W'(127 - MANT_SHIFT)
              + {{(E_W-P_W){1'b0}}, s1_pos_q};
    norm_sh = P_W'(ACC_W - 1) - s1_pos_q;
    norm    = {s1_mag_q, 23'b0} << norm_sh;
    mant    = norm[ACC_W+21 -: 23];
    if ((s1_mag_q == '0) || (relu_q && s1_sign_q))
      packed_word = 32'h0000_0000;
    else if (e_sum[E_W-1] || (e_sum == '0))
      packed_word = {s1_sign_q, 31'b0};
    else if (e_sum >= E_W'(255))
      packed_word = {s1_sign_q, 8'hFF, 23'b0};
    else
      packed_word = {s1_sign_q, e_sum[7:0], mant};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    relu_d      = relu_q;
    sgn_snap_d  = sgn_snap_q;
    exp_snap_d  = exp_snap_q;
    acc_snap_d  = acc_snap_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_mag_d    = s1_mag_q;
    s1_pos_d    = s1_pos_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    ovr_d       = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sgn_snap_d = signo;
          exp_snap_d = expo;
          acc_snap_d = addo;
          n_d        = ((nch == 7'd0) || (nch > 7'(F_NUM))) ? 7'(F_NUM) : nch;
          relu_d     = relu;
          cnt_d      = 7'd0;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (issue) begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == n_q - 7'd1) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (out_valid_q && dst_ready && out_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A start seen outside IDLE is dropped; setting takes priority over clearing.
    if (start && (state_q != ST_IDLE)) ovr_d = 1'b1;
    else if (clr_ovr)                   ovr_d = 1'b0;

    if (s1_valid_q && advance) s1_valid_d = 1'b0;
    if (issue) begin
      s1_valid_d = 1'b1;
      s1_last_d  = (cnt_q == n_q - 7'd1);
      s1_sign_d  = sel_sgn ^ sel_acc[ACC_W-1];
      s1_exp_d   = sel_exp;
      s1_mag_d   = sel_mag;
      s1_pos_d   = sel_pos;
    end

    if (advance) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) out_data_d = packed_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      relu_q      <= 1'b0;
      sgn_snap_q  <= '0;
      exp_snap_q  <= '0;
      acc_snap_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mag_q    <= '0;
      s1_pos_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      relu_q      <= relu_d;
      sgn_snap_q  <= sgn_snap_d;
      exp_snap_q  <= exp_snap_d;
      acc_snap_q  <= acc_snap_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_mag_q    <= s1_mag_d;
      s1_pos_q    <= s1_pos_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      ovr_q       <= ovr_d;
    end
  end

  assign dst_valid = out_valid_q;
  assign dst_data  = out_data_q;
  assign dst_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nrm_drain.sv
// Directed bench for nrm_drain: single-channel vector table, multi-channel drains,
// random backpressure, overrun and mid-drain reset sequences.
module tb_nrm_drain;

  localparam int F_NUM = 16;
  localparam int EXP_W = 10;
  localparam int ACC_W = 32;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic [6:0]               nch;
  logic                     relu;
  logic [F_NUM-1:0]         signo;
  logic [F_NUM*EXP_W-1:0]   expo;
  logic [F_NUM*ACC_W-1:0]   addo;
  logic                     dst_valid;
  logic [31:0]              dst_data;
  logic                     dst_last;
  logic                     dst_ready;
  logic                     busy;
  logic                     overrun;
  logic                     clr_ovr;
  logic [1:0]               dbg_state;

  nrm_drain #(.F_NUM(F_NUM), .EXP_W(EXP_W), .ACC_W(ACC_W), .MANT_SHIFT(23)) dut (
    .clk(clk), .reset(reset), .start(start), .nch(nch), .relu(relu),
    .signo(signo), .expo(expo), .addo(addo),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready),
    .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic        sgn;
    logic [9:0]  ex;
    logic [31:0] acc;
    logic        rl;
    logic [31:0] word;
  } vec_t;
  vec_t vt [18];

  logic [31:0] int_words [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic set_ch(input int i, input logic s, input logic [9:0] e, input logic [31:0] a);
    signo[i] = s;
    expo[i*EXP_W +: EXP_W] = e;
    addo[i*ACC_W +: ACC_W] = a;
  endtask

  task automatic scramble();
    for (int i = 0; i < F_NUM; i++)
      set_ch(i, 1'($urandom_range(0, 1)), 10'($urandom), $urandom);
  endtask

  task automatic do_start(input logic [6:0] n, input logic r);
    start = 1'b1;
    nch   = n;
    relu  = r;
    tick();
    start = 1'b0;
  endtask

  task automatic load_case4();
    set_ch(0, 1'b0, 10'sd23, 32'hFFFF_FFFD);
    set_ch(1, 1'b0, 10'sd0,  32'h00C0_0000);
    set_ch(2, 1'b0, 10'sd5,  32'h0000_0000);
    set_ch(3, 1'b1, 10'sd23, 32'h0000_0001);
  endtask

  // scoreboard: consumes exp_q, checks order, last flag and stability while stalled
  task automatic collect(input int budget, input int ready_pct);
    int          cyc;
    logic        held_v;
    logic [32:0] held_w;
    logic [32:0] got;
    cyc    = 0;
    held_v = 1'b0;
    held_w = '0;
    while (exp_q.size() > 0 && cyc < budget) begin
      dst_ready = ($urandom_range(0, 99) < ready_pct);
      got = {dst_last, dst_data};
      if (held_v) begin
        chk("stall_valid", 64'(dst_valid), 64'd1);
        chk("stall_hold", 64'(got), 64'(held_w));
      end
      if (dst_valid && dst_ready) chk("word", 64'(got), 64'(exp_q.pop_front()));
      held_v = dst_valid && !dst_ready;
      held_w = got;
      tick();
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    dst_ready = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b0,  10'sd23,  32'h0000_0001, 1'b0, 32'h3F80_0000};
    vt[1]  = '{1'b0,  10'sd23,  32'hFFFF_FFFD, 1'b0, 32'hC040_0000};
    vt[2]  = '{1'b0,  10'sd0,   32'h00C0_0000, 1'b0, 32'h3FC0_0000};
    vt[3]  = '{1'b0,  10'sd23,  32'h0000_0000, 1'b0, 32'h0000_0000};
    vt[4]  = '{1'b1,  10'sd23,  32'h0000_0001, 1'b0, 32'hBF80_0000};
    vt[5]  = '{1'b0, -10'sd200, 32'h0000_0001, 1'b0, 32'h0000_0000};
    vt[6]  = '{1'b0,  10'sd200, 32'h7FFF_FFFF, 1'b0, 32'h7F80_0000};
    vt[7]  = '{1'b0,  10'sd23,  32'h8000_0000, 1'b0, 32'hCF00_0000};
    vt[8]  = '{1'b1,  10'sd23,  32'h0000_0001, 1'b1, 32'h0000_0000};
    vt[9]  = '{1'b1, -10'sd200, 32'h0000_0001, 1'b0, 32'h8000_0000};
    vt[10] = '{1'b1,  10'sd200, 32'h0000_0001, 1'b0, 32'hFF80_0000};
    vt[11] = '{1'b1,  10'sd23,  32'hFFFF_FFFF, 1'b1, 32'h3F80_0000};
    vt[12] = '{1'b0,  10'sd20,  32'h0000_0005, 1'b0, 32'h3F20_0000};
    vt[13] = '{1'b0, -10'sd103, 32'h0000_0001, 1'b0, 32'h0080_0000};
    vt[14] = '{1'b0,  10'sd150, 32'h0000_0001, 1'b0, 32'h7F00_0000};
    vt[15] = '{1'b0,  10'sd151, 32'h0000_0001, 1'b0, 32'h7F80_0000};
    vt[16] = '{1'b0, -10'sd104, 32'h0000_0001, 1'b0, 32'h0000_0000};
    vt[17] = '{1'b0,  10'sd23,  32'h7FFF_FFFF, 1'b0, 32'h4EFF_FFFF};
    int_words = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                  32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                  32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
                  32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};

    reset = 1'b1; start = 1'b0; nch = '0; relu = 1'b0;
    signo = '0; expo = '0; addo = '0; dst_ready = 1'b1; clr_ovr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", 64'(dst_valid), 64'd0);
    chk("rst_data", 64'(dst_data), 64'd0);
    chk("rst_last", 64'(dst_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);

    // single-channel vectors with exact latency
    for (int v = 0; v < 18; v++) begin
      scramble();
      set_ch(0, vt[v].sgn, vt[v].ex, vt[v].acc);
      do_start(7'd1, vt[v].rl);
      scramble();
      chk("v_busy_t1", 64'(busy), 64'd1);
      chk("v_valid_t1", 64'(dst_valid), 64'd0);
      tick();
      chk("v_valid_t2", 64'(dst_valid), 64'd0);
      tick();
      chk("v_valid_t3", 64'(dst_valid), 64'd1);
      chk("v_data", 64'(dst_data), 64'(vt[v].word));
      chk("v_last", 64'(dst_last), 64'd1);
      tick();
      chk("v_busy_t4", 64'(busy), 64'd0);
      chk("v_valid_t4", 64'(dst_valid), 64'd0);
    end

    // four channels, without and with relu
    scramble();
    load_case4();
    exp_q.push_back({1'b0, 32'hC040_0000});
    exp_q.push_back({1'b0, 32'h3FC0_0000});
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b1, 32'hBF80_0000});
    do_start(7'd4, 1'b0);
    scramble();
    collect(40, 100);
    chk("n4_idle", 64'({busy, dst_valid}), 64'd0);

    load_case4();
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b0, 32'h3FC0_0000});
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b1, 32'h0000_0000});
    do_start(7'd4, 1'b1);
    scramble();
    collect(40, 100);

    // all 16 channels via nch=0 under random backpressure
    for (int i = 0; i < F_NUM; i++) begin
      set_ch(i, 1'b0, 10'sd23, 32'(i + 1));
      exp_q.push_back({(i == F_NUM - 1), int_words[i]});
    end
    do_start(7'd0, 1'b0);
    scramble();
    collect(400, 50);
    chk("bp_idle", 64'({busy, dst_valid}), 64'd0);

    // overrun: second start at t+5 must not disturb the drain
    load_case4();
    do_start(7'd4, 1'b0);
    tick();
    tick();
    chk("ovr_w0", 64'({dst_valid, dst_last, dst_data}), {31'd0, 1'b1, 1'b0, 32'hC040_0000});
    tick();
    chk("ovr_w1", 64'({dst_valid, dst_last, dst_data}), {31'd0, 1'b1, 1'b0, 32'h3FC0_0000});
    tick();
    chk("ovr_w2", 64'({dst_valid, dst_last, dst_data}), {31'd0, 1'b1, 1'b0, 32'h0000_0000});
    start = 1'b1; nch = 7'd1;
    scramble();
    tick();
    start = 1'b0;
    chk("ovr_w3", 64'({dst_valid, dst_last, dst_data}), {31'd0, 1'b1, 1'b1, 32'hBF80_0000});
    chk("ovr_set", 64'(overrun), 64'd1);
    tick();
    chk("ovr_idle", 64'({busy, dst_valid}), 64'd0);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    tick();
    chk("ovr_no_drain", 64'(dst_valid), 64'd0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'd0);

    // start on the final handshake is ignored; set beats clear; next cycle accepts
    set_ch(0, 1'b0, 10'sd23, 32'd1);
    do_start(7'd1, 1'b0);
    tick();
    tick();
    chk("fh_last", 64'({dst_valid, dst_last}), 64'd3);
    start = 1'b1; nch = 7'd4; clr_ovr = 1'b1;
    tick();
    start = 1'b0; clr_ovr = 1'b0;
    chk("fh_busy", 64'(busy), 64'd0);
    chk("fh_ovr", 64'(overrun), 64'd1);
    set_ch(0, 1'b0, 10'sd24, 32'd1);
    exp_q.push_back({1'b1, 32'h4000_0000});
    do_start(7'd1, 1'b0);
    chk("fh_accept", 64'(busy), 64'd1);
    collect(20, 100);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // reset mid-drain, then a clean drain from channel 0
    load_case4();
    do_start(7'd4, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mr_ovr_pre", 64'(overrun), 64'd1);
    tick();
    tick();
    chk("mr_valid_pre", 64'({dst_valid, dst_data}), {31'd0, 1'b1, 32'h3FC0_0000});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_valid", 64'(dst_valid), 64'd0);
    chk("mr_data", 64'(dst_data), 64'd0);
    chk("mr_last", 64'(dst_last), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ovr", 64'(overrun), 64'd0);
    tick();
    chk("mr_quiet", 64'(dst_valid), 64'd0);
    exp_q.push_back({1'b0, 32'hC040_0000});
    exp_q.push_back({1'b0, 32'h3FC0_0000});
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b1, 32'hBF80_0000});
    do_start(7'd4, 1'b0);
    scramble();
    collect(40, 100);
    chk("mr_idle", 64'({busy, dst_valid}), 64'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
